// File: rtl/fuzzy_pkg.sv
// Shared types and membership helpers for the fuzzy risk engine.
// The helpers work in 32-bit arithmetic; callers truncate to the datapath width.
package fuzzy_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_EVAL,
    ST_SUM,
    ST_DIV,
    ST_DONE
  } state_e;

  localparam logic [1:0] LVL_LOW  = 2'd0;
  localparam logic [1:0] LVL_MED  = 2'd1;
  localparam logic [1:0] LVL_HIGH = 2'd2;

  // Left shift that clamps to maxv instead of wrapping.
  function automatic logic [31:0] sat_shl(input logic [31:0] v, input logic [31:0] sh,
                                          input logic [31:0] maxv);
    logic [31:0] t;
    t = v << sh;
    return ((t > maxv) || ((t >> sh) != v)) ? maxv : t;
  endfunction

  function automatic logic [31:0] mu_low(input logic [31:0] x, input logic [31:0] bp_a,
                                         input logic [31:0] bp_b, input logic [31:0] maxv,
                                         input logic [31:0] sh);
    if (x <= bp_a) return maxv;
    else if (x >= bp_b) return 32'd0;
    else return sat_shl(bp_b - x, sh, maxv);
  endfunction

  function automatic logic [31:0] mu_high(input logic [31:0] x, input logic [31:0] bp_a,
                                          input logic [31:0] bp_b, input logic [31:0] maxv,
                                          input logic [31:0] sh);
    if (x <= bp_a) return 32'd0;
    else if (x >= bp_b) return maxv;
    else return sat_shl(x - bp_a, sh, maxv);
  endfunction

  // Medium peaks where low and high cross, so it is twice their minimum.
  function automatic logic [31:0] mu_med(input logic [31:0] lo, input logic [31:0] hi,
                                         input logic [31:0] maxv);
    return sat_shl((lo < hi) ? lo : hi, 32'd1, maxv);
  endfunction

endpackage

// File: rtl/fuzzy_risk_engine_seq_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge, so done rises QW cycles after start.
module seq_divider #(
  parameter int unsigned NW = 18,
  parameter int unsigned DW = 10,
  parameter int unsigned QW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [QW-1:0] quo,
  output logic          done,
  output logic          dz
);

  localparam int unsigned CW = $clog2(QW + 1);

  logic [DW-1:0] rem, rem_src, rem_nxt;
  logic [QW-1:0] q_src, q_nxt;
  logic [DW:0]   trial;
  logic [CW-1:0] left;
  logic          run;

  // Quotient bits shift into the bottom of quo as numerator bits leave the top.
  always_comb begin
    rem_src = start ? num[NW-1 -: DW] : rem;
    q_src   = start ? num[QW-1:0] : quo;
    trial   = {rem_src, q_src[QW-1]};
    if (trial >= {1'b0, den}) begin
      rem_nxt = DW'(trial - {1'b0, den});
      q_nxt   = {q_src[QW-2:0], 1'b1};
    end else begin
      rem_nxt = DW'(trial);
      q_nxt   = {q_src[QW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      left <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      dz   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || run) begin
        rem <= rem_nxt;
        quo <= q_nxt;
      end
      if (start) begin
        dz   <= (den == '0);
        run  <= 1'b1;
        left <= CW'(QW - 1);
      end else if (run) begin
        left <= left - 1'b1;
        if (left == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fuzzy_risk_engine.sv
// Multi-channel fuzzy risk estimator: load a frame, fuzzify per channel,
// aggregate rule strengths and defuzzify by weighted-singleton average.
module fuzzy_risk_engine
  import fuzzy_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned N_IN      = 2,
  parameter int unsigned BP_A      = 64,
  parameter int unsigned SPAN_LOG2 = 7,
  parameter int unsigned OUT_L     = 0,
  parameter int unsigned OUT_M     = 128,
  parameter int unsigned OUT_H     = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ss,
  input  logic [W-1:0] data_bus,
  output logic [W-1:0] risk,
  output logic         risk_valid,
  output logic [1:0]   level,
  output logic         busy,
  output logic         ovr
);

  localparam int unsigned MAX  = (2 ** W) - 1;
  localparam int unsigned BP_B = BP_A + (2 ** SPAN_LOG2);
  localparam int unsigned SH   = W - SPAN_LOG2;
  localparam int unsigned NW   = 2 * W + 2;
  localparam int unsigned DW   = W + 2;
  localparam int unsigned CH_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_e        state, state_d;
  logic [CH_W-1:0] cnt, ch;
  logic [W-1:0]  slot [N_IN];
  logic [W-1:0]  s_l, s_m, s_h;
  logic [W-1:0]  lo_c, med_c, hi_c;
  logic [NW-1:0] num_c;
  logic [DW-1:0] den_c;
  logic [1:0]    lvl_c;
  logic          accept_c, last_c, div_start_c;
  logic [W-1:0]  div_quo;
  logic          div_done, div_dz;

  assign accept_c = ss && (state == ST_LOAD);
  assign last_c   = accept_c && (cnt == CH_W'(N_IN - 1));

  // Membership of the channel currently being evaluated.
  assign lo_c  = W'(mu_low(32'(slot[ch]), 32'(BP_A), 32'(BP_B), 32'(MAX), 32'(SH)));
  assign hi_c  = W'(mu_high(32'(slot[ch]), 32'(BP_A), 32'(BP_B), 32'(MAX), 32'(SH)));
  assign med_c = W'(mu_med(32'(lo_c), 32'(hi_c), 32'(MAX)));

  assign num_c = NW'(s_l) * NW'(OUT_L) + NW'(s_m) * NW'(OUT_M) + NW'(s_h) * NW'(OUT_H);
  assign den_c = DW'(s_l) + DW'(s_m) + DW'(s_h);

  // Dominant rule; ties go to the higher-risk level.
  always_comb begin
    lvl_c = LVL_LOW;
    if ((s_h >= s_m) && (s_h >= s_l)) lvl_c = LVL_HIGH;
    else if (s_m >= s_l) lvl_c = LVL_MED;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    div_start_c = 1'b0;
    case (state)
      ST_LOAD: if (last_c) state_d = ST_EVAL;
      ST_EVAL: if (ch == CH_W'(N_IN - 1)) state_d = ST_SUM;
      ST_SUM: begin
        div_start_c = 1'b1;
        state_d     = ST_DIV;
      end
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept_c) slot[cnt] <= data_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      ch         <= '0;
      s_l        <= W'(MAX);
      s_m        <= '0;
      s_h        <= '0;
      risk       <= '0;
      level      <= LVL_LOW;
      risk_valid <= 1'b0;
      busy       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      risk_valid <= 1'b0;
      busy       <= (state_d == ST_EVAL) || (state_d == ST_SUM) || (state_d == ST_DIV);
      // Bytes outside LOAD are dropped; the first byte of a new frame clears the flag.
      if (accept_c) begin
        cnt <= last_c ? '0 : cnt + 1'b1;
        if (cnt == '0) ovr <= 1'b0;
      end else if (ss) begin
        ovr <= 1'b1;
      end
      if (last_c) begin
        ch  <= '0;
        s_l <= W'(MAX);
        s_m <= '0;
        s_h <= '0;
      end
      if (state == ST_EVAL) begin
        ch  <= ch + 1'b1;
        s_l <= (lo_c < s_l) ? lo_c : s_l;
        s_m <= (med_c > s_m) ? med_c : s_m;
        s_h <= (hi_c > s_h) ? hi_c : s_h;
      end
      if ((state == ST_DIV) && div_done) begin
        risk_valid <= 1'b1;
        if (div_dz) begin
          risk  <= W'(OUT_M);
          level <= LVL_MED;
        end else begin
          risk  <= div_quo;
          level <= lvl_c;
        end
      end
    end
  end

  seq_divider #(
    .NW (NW),
    .DW (DW),
    .QW (W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start_c),
    .num   (num_c),
    .den   (den_c),
    .quo   (div_quo),
    .done  (div_done),
    .dz    (div_dz)
  );

endmodule

// File: tb/tb_fuzzy_risk_engine.sv
// Directed and randomized frames for fuzzy_risk_engine at default parameters,
// checked against an arithmetic model of the membership/rule/centroid rules.
module tb_fuzzy_risk_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic [7:0] data_bus;
  logic [7:0] risk;
  logic       risk_valid;
  logic [1:0] level;
  logic       busy;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  logic [7:0] corner [10] = '{8'd0, 8'd63, 8'd64, 8'd65, 8'd127,
                              8'd128, 8'd191, 8'd192, 8'd193, 8'd255};

  fuzzy_risk_engine dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .data_bus   (data_bus),
    .risk       (risk),
    .risk_valid (risk_valid),
    .level      (level),
    .busy       (busy),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Memberships on a 64..192 ramp scaled by 2, rules aggregated, centroid of singletons 0/128/255.
  function automatic void model(input int x0, input int x1, output int r, output int l);
    int xs [2];
    int lo, hi, md, sl, sm, sh, num, den;
    xs[0] = x0;
    xs[1] = x1;
    sl = 255; sm = 0; sh = 0;
    for (int i = 0; i < 2; i++) begin
      if (xs[i] <= 64) begin lo = 255; hi = 0; end
      else if (xs[i] >= 192) begin lo = 0; hi = 255; end
      else begin
        lo = (192 - xs[i]) * 2; if (lo > 255) lo = 255;
        hi = (xs[i] - 64) * 2;  if (hi > 255) hi = 255;
      end
      md = 2 * ((lo < hi) ? lo : hi);
      if (md > 255) md = 255;
      if (lo < sl) sl = lo;
      if (md > sm) sm = md;
      if (hi > sh) sh = hi;
    end
    num = sl * 0 + sm * 128 + sh * 255;
    den = sl + sm + sh;
    if (den == 0) begin
      r = 128; l = 1;
    end else begin
      r = num / den;
      l = (sh >= sm && sh >= sl) ? 2 : ((sm >= sl) ? 1 : 0);
    end
  endfunction

  function automatic logic [7:0] pick();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 9)];
    return 8'($urandom_range(0, 255));
  endfunction

  // Sends one frame, watches latency/busy/hold/ovr, optionally injects a stray byte at cycle ovr_k.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                           input int ovr_k, input logic [7:0] ovr_b,
                           input logic [7:0] exp_r, input logic [1:0] exp_l, input string tag);
    logic [7:0] prev;
    int lat;
    bit hold_ok;
    @(negedge clk);
    prev = risk;
    ss = 1'b1;
    data_bus = b0;
    @(negedge clk);
    check({tag, "_ovr_clear"}, 32'(ovr), 32'd0);
    if (gap > 0) begin
      ss = 1'b0;
      repeat (gap) @(negedge clk);
      ss = 1'b1;
    end
    data_bus = b1;
    @(negedge clk);
    ss = 1'b0;
    check({tag, "_busy_eval"}, 32'(busy), 32'd1);
    lat = -1;
    hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (risk_valid) begin
        lat = k;
        break;
      end
      if (risk !== prev) hold_ok = 1'b0;
      if (k == ovr_k) begin
        ss = 1'b1;
        data_bus = ovr_b;
      end else begin
        ss = 1'b0;
      end
    end
    ss = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd12);
    check({tag, "_risk"}, 32'(risk), 32'(exp_r));
    check({tag, "_level"}, 32'(level), 32'(exp_l));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_ovr"}, 32'(ovr), (ovr_k > 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, "_pulse_width"}, 32'(risk_valid), 32'd0);
    check({tag, "_risk_held"}, 32'(risk), 32'(exp_r));
  endtask

  initial begin
    int r, l;
    bit seen;
    logic [7:0] a, b;
    rst = 1'b1;
    ss = 1'b0;
    data_bus = '0;
    repeat (3) @(negedge clk);
    check("rst_risk", 32'(risk), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(risk_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;

    run_frame(8'd0, 8'd0, 0, 0, 8'd0, 8'd0, 2'd0, "f00");
    run_frame(8'd255, 8'd255, 0, 0, 8'd0, 8'd255, 2'd2, "fff");
    run_frame(8'd128, 8'd128, 0, 0, 8'd0, 8'd127, 2'd1, "f128");
    run_frame(8'd0, 8'd255, 0, 0, 8'd0, 8'd255, 2'd2, "f0ff");
    run_frame(8'd128, 8'd128, 0, 6, 8'd255, 8'd127, 2'd1, "f128_ovr");
    // A leaked stray 255 would complete this frame early with a non-zero result.
    run_frame(8'd0, 8'd0, 0, 0, 8'd0, 8'd0, 2'd0, "after_ovr");
    run_frame(8'd255, 8'd255, 2, 0, 8'd0, 8'd255, 2'd2, "gap");

    // Reset three cycles into processing aborts the frame.
    @(negedge clk);
    ss = 1'b1;
    data_bus = 8'd128;
    @(negedge clk);
    @(negedge clk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_risk", 32'(risk), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    check("abort_valid", 32'(risk_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ovr", 32'(ovr), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (risk_valid) seen = 1'b1;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);
    run_frame(8'd255, 8'd255, 0, 0, 8'd0, 8'd255, 2'd2, "post_abort");

    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      model(int'(a), int'(b), r, l);
      run_frame(a, b, int'($urandom_range(0, 3)), 0, 8'd0, 8'(r), 2'(l), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fuzzy_risk_engine.md
Name: fuzzy_risk_engine

Overview:
- Parametrised successor to the single-channel fuzzy risk estimator.
- Accepts a frame of N_IN sensor bytes strobed in over `data_bus` with `ss`, then runs a sequential pipeline: fuzzify each channel (LOW/MED/HIGH), aggregate rule strengths, defuzzify by weighted-singleton average through an iterative divider.
- Presents a registered risk value, a dominant-level code and handshake flags.
- Sits directly behind the chip-level pin wrapper.

Parameters:
- W, 8, data and membership width in bits.
- N_IN, 2, channels per frame (1..4).
- BP_A, 64, lower membership breakpoint.
- SPAN_LOG2, 7, breakpoint span; upper breakpoint B = BP_A + 2^SPAN_LOG2; must satisfy SPAN_LOG2 <= W and B <= 2^W-1.
- OUT_L, 0, LOW output singleton.
- OUT_M, 128, MED output singleton.
- OUT_H, 255, HIGH output singleton; OUT_* < 2^W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ss  in  1  byte strobe; data_bus sampled on each clk edge where ss=1 and busy=0.
- data_bus  in  W  channel sample, channel 0 first.
- risk  out  W  defuzzified risk, held until next result.
- risk_valid  out  1  one-cycle pulse when risk updates.
- level  out  2  dominant rule: 0 LOW, 1 MED, 2 HIGH.
- busy  out  1  high from EVAL through DIV.
- ovr  out  1  sticky overrun flag.

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high. Reset values: risk=0, level=0, risk_valid=0, busy=0, ovr=0, byte count=0, state=LOAD.
- States and transitions:
  - LOAD: each accepted byte stores to slot[cnt], cnt++. The byte with cnt=N_IN-1 (cycle t0) moves to EVAL and clears cnt.
  - EVAL: N_IN cycles, one channel per cycle, in order.
  - SUM: 1 cycle.
  - DIV: W cycles.
  - DONE: 1 cycle, then back to LOAD.
- Latency: risk, level and risk_valid update at t0+N_IN+W+2 (12 cycles at defaults). busy is high from t0+1 through the last DIV cycle.
- Membership per channel x (MAX = 2^W-1, sh = W-SPAN_LOG2):
  - x<=BP_A: low=MAX, high=0.
  - x>=B: low=0, high=MAX.
  - Otherwise: low=min(MAX,(B-x)<<sh), high=min(MAX,(x-BP_A)<<sh).
  - med = min(MAX, 2*min(low,high)).
- Aggregation:
  - S_L = min over channels of low; initialised to MAX.
  - S_M = max of med; initialised to 0.
  - S_H = max of high; initialised to 0.
- SUM: num = S_L*OUT_L + S_M*OUT_M + S_H*OUT_H (2W+2 bits); den = S_L+S_M+S_H (W+2 bits).
- DIV:
  - Restoring divide, one quotient bit per cycle, MSB first.
  - Result is floor(num/den), W bits; the quotient is bounded by OUT_H, so it never overflows.
  - den=0 forces risk=OUT_M and level=1; the W-cycle latency is unchanged.
- level = argmax(S_L,S_M,S_H). Ties resolve to the higher-risk level (H > M > L).
- Boundary and error cases:
  - ss=1 while busy=1 or in DONE: byte is discarded and ovr sets.
  - ovr clears only on reset or on the first accepted byte of the next frame.
  - risk holds its old value throughout any frame.
  - Partial frame: cnt holds indefinitely; there is no timeout.
  - Reset mid-frame or mid-DIV aborts with no risk_valid pulse, and outputs take their reset values.
  - ss held high across consecutive idle cycles loads one byte per cycle.

Decomposition:
- Shared package fuzzy_pkg holds:
  - state enum (LOAD, EVAL, SUM, DIV, DONE);
  - level codes LVL_LOW/LVL_MED/LVL_HIGH;
  - a saturating-shift membership function.
- One sub-module, seq_divider, parametrised by numerator, denominator and quotient widths.
  - start/done handshake.
  - Fixed W-cycle latency.
  - den=0 flag.

Test Plan (W=8, N_IN=2, BP_A=64, SPAN_LOG2=7):
- Frame {0,0} -> S_L=255, S_M=0, S_H=0; risk=0, level=0; risk_valid pulse exactly 12 cycles after the second ss.
- Frame {255,255} -> risk=255, level=2.
- Frame {128,128} -> low=high=128, med=255; num=65280, den=511; risk=127, level=1.
- Frame {0,255} -> S_L=0, S_M=0, S_H=255; risk=255, level=2.
- Frame {128,128}, ss pulsed during DIV -> ovr=1, result still 127.
  - Next frame first byte clears ovr.
  - The discarded byte does not enter the next frame.
- Two bytes loaded, rst asserted 3 cycles later -> no risk_valid, all outputs 0.
  - A following frame {255,255} yields 255 with normal latency.
